// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue: NOP encoding,
// default widths and the pointer-width helper.
package fetch_decode_queue_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_NPC_W   = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_STALL_W = 16;

  // MIPS sll $0,$0,0
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_mem.sv
// Entry storage for the fetch/decode queue: one synchronous write port,
// one asynchronous read port, no reset.
module fetch_decode_queue_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: valid/ready on both sides,
// synchronous flush on taken branch, saturating stall counter.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 NPC_W     = DEF_NPC_W,
  parameter int                 DEPTH     = DEF_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_ENC),
  parameter int                 STALL_W   = DEF_STALL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [INSTR_W-1:0]      push_instr,
  input  logic [NPC_W-1:0]        push_npc,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [INSTR_W-1:0]      pop_instr,
  output logic [NPC_W-1:0]        pop_npc,
  input  logic                    flush,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty,
  output logic [STALL_W-1:0]      stall_cnt
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [STALL_W-1:0]       stall_q, stall_d;
  logic                     push_fire, pop_fire;
  logic [INSTR_W+NPC_W-1:0] head;

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  // push_ready depends only on registered occupancy, never on pop_ready
  assign push_ready = ~full;
  assign pop_valid  = ~empty & ~flush;
  assign push_fire  = push_valid & push_ready & ~flush;
  assign pop_fire   = pop_valid & pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (push_valid && !push_ready && !(&stall_q)) stall_d = stall_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  fetch_decode_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (INSTR_W + NPC_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr_q),
    .wdata ({push_instr, push_npc}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign pop_instr = pop_valid ? head[INSTR_W+NPC_W-1 -: INSTR_W] : NOP_INSTR;
  assign pop_npc   = pop_valid ? head[NPC_W-1:0] : '0;
  assign count     = count_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int NW    = 32;
  localparam int SW    = 4;
  localparam int CW    = 3;
  localparam int SMAX  = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0;
  logic          pop_ready  = 1'b0;
  logic          flush      = 1'b0;
  logic [IW-1:0] push_instr = '0;
  logic [NW-1:0] push_npc   = '0;
  logic          push_ready, pop_valid, full, empty;
  logic [IW-1:0] pop_instr;
  logic [NW-1:0] pop_npc;
  logic [CW-1:0] count;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  int          mstall = 0;

  fetch_decode_queue #(
    .INSTR_W (IW),
    .NPC_W   (NW),
    .DEPTH   (DEPTH),
    .STALL_W (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_instr (push_instr),
    .push_npc   (push_npc),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_instr  (pop_instr),
    .pop_npc    (pop_npc),
    .flush      (flush),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        pr;
    logic [2:0]  e_count;
    logic        e_pv;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic [3:0]  e_stall;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit mfull, mpv;
    logic [31:0] ei, en;
    mfull = (mq.size() == DEPTH);
    mpv   = (mq.size() != 0) && !flush;
    ei = 32'h0;
    en = 32'h0;
    if (mpv) begin
      ei = mq[0][63:32];
      en = mq[0][31:0];
    end
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_full", 64'(full), 64'(mfull));
    chk("m_empty", 64'(empty), 64'(mq.size() == 0));
    chk("m_push_ready", 64'(push_ready), 64'(!mfull));
    chk("m_pop_valid", 64'(pop_valid), 64'(mpv));
    chk("m_pop_instr", 64'(pop_instr), 64'(ei));
    chk("m_pop_npc", 64'(pop_npc), 64'(en));
    chk("m_stall", 64'(stall_cnt), 64'(mstall));
  endtask

  task automatic update_model();
    bit mfull, mpv;
    mfull = (mq.size() == DEPTH);
    mpv   = (mq.size() != 0) && !flush;
    if (push_valid && mfull && mstall < SMAX) mstall++;
    if (flush) mq.delete();
    else begin
      if (mpv && pop_ready) void'(mq.pop_front());
      if (push_valid && !mfull) mq.push_back({push_instr, push_npc});
    end
  endtask

  // Inputs already set by caller; check, clock, advance model.
  task automatic step();
    #1;
    compare_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mstall = 0;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [31:0] npc);
    push_valid = 1'b1;
    push_instr = ins;
    push_npc   = npc;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    step();
    push_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h2001_0001, 32'd4,  1'b0, 3'd0, 1'b0, 32'h0,         32'd0,  4'd0};
    tbl[1] = '{1'b1, 32'h2001_0002, 32'd8,  1'b0, 3'd1, 1'b1, 32'h2001_0001, 32'd4,  4'd0};
    tbl[2] = '{1'b1, 32'h2001_0003, 32'd12, 1'b0, 3'd2, 1'b1, 32'h2001_0001, 32'd4,  4'd0};
    tbl[3] = '{1'b1, 32'h2001_0004, 32'd16, 1'b0, 3'd3, 1'b1, 32'h2001_0001, 32'd4,  4'd0};
    tbl[4] = '{1'b1, 32'h2001_0005, 32'd20, 1'b0, 3'd4, 1'b1, 32'h2001_0001, 32'd4,  4'd0};
    tbl[5] = '{1'b0, 32'h0,         32'd0,  1'b1, 3'd4, 1'b1, 32'h2001_0001, 32'd4,  4'd1};
    tbl[6] = '{1'b0, 32'h0,         32'd0,  1'b1, 3'd3, 1'b1, 32'h2001_0002, 32'd8,  4'd1};
    tbl[7] = '{1'b0, 32'h0,         32'd0,  1'b1, 3'd2, 1'b1, 32'h2001_0003, 32'd12, 4'd1};
    tbl[8] = '{1'b0, 32'h0,         32'd0,  1'b1, 3'd1, 1'b1, 32'h2001_0004, 32'd16, 4'd1};
    tbl[9] = '{1'b0, 32'h0,         32'd0,  1'b1, 3'd0, 1'b0, 32'h0,         32'd0,  4'd1};

    // Reset values
    do_reset();
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_pop_instr", 64'(pop_instr), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    $display("reset check done");

    // Fill and drain
    for (int i = 0; i < 10; i++) begin
      push_valid = tbl[i].pv;
      push_instr = tbl[i].instr;
      push_npc   = tbl[i].npc;
      pop_ready  = tbl[i].pr;
      flush      = 1'b0;
      #1;
      chk("tbl_count", 64'(count), 64'(tbl[i].e_count));
      chk("tbl_pop_valid", 64'(pop_valid), 64'(tbl[i].e_pv));
      chk("tbl_pop_instr", 64'(pop_instr), 64'(tbl[i].e_instr));
      chk("tbl_pop_npc", 64'(pop_npc), 64'(tbl[i].e_npc));
      chk("tbl_stall", 64'(stall_cnt), 64'(tbl[i].e_stall));
      $display("vec %0d: count=%0d pop_valid=%0d pop_instr=%h stall=%0d", i, count, pop_valid, pop_instr, stall_cnt);
      step();
    end

    // Simultaneous push/pop at count=2, pointers wrap
    do_reset();
    push_one(32'h3000_0000, 32'd0);
    push_one(32'h3000_0001, 32'd4);
    for (int k = 0; k < 10; k++) begin
      push_valid = 1'b1;
      push_instr = 32'h3000_0000 + 32'(k + 2);
      push_npc   = 32'((k + 2) * 4);
      pop_ready  = 1'b1;
      #1;
      chk("pp_count", 64'(count), 64'd2);
      chk("pp_order", 64'(pop_instr), 64'(32'h3000_0000 + 32'(k)));
      $display("push/pop %0d: count=%0d head=%h", k, count, pop_instr);
      step();
    end
    push_valid = 1'b0;
    pop_ready  = 1'b0;

    // Flush with count=3 and a concurrent push
    do_reset();
    push_one(32'h4000_0001, 32'd4);
    push_one(32'h4000_0002, 32'd8);
    push_one(32'h4000_0003, 32'd12);
    push_valid = 1'b1;
    push_instr = 32'hDEAD_BEEF;
    push_npc   = 32'd16;
    flush      = 1'b1;
    pop_ready  = 1'b1;
    #1;
    chk("fl_pop_valid_during", 64'(pop_valid), 64'd0);
    step();
    push_valid = 1'b0;
    flush      = 1'b0;
    #1;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_pop_valid", 64'(pop_valid), 64'd0);
    chk("fl_pop_instr", 64'(pop_instr), 64'h0);
    chk("fl_push_ready", 64'(push_ready), 64'd1);
    $display("flush: count=%0d pop_valid=%0d pop_instr=%h", count, pop_valid, pop_instr);
    step();
    pop_ready = 1'b0;
    push_one(32'h4000_0010, 32'd64);
    pop_ready = 1'b1;
    #1;
    chk("fl_head_after", 64'(pop_instr), 64'h4000_0010);
    step();
    #1;
    chk("fl_empty_after", 64'(empty), 64'd1);
    pop_ready = 1'b0;

    // Asynchronous reset between edges
    do_reset();
    push_one(32'h5000_0001, 32'd4);
    push_one(32'h5000_0002, 32'd8);
    #1;
    chk("ar_pre_count", 64'(count), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_empty", 64'(empty), 64'd1);
    chk("ar_pop_valid", 64'(pop_valid), 64'd0);
    chk("ar_pop_instr", 64'(pop_instr), 64'h0);
    chk("ar_push_ready", 64'(push_ready), 64'd1);
    $display("async reset: count=%0d empty=%0d pop_valid=%0d", count, empty, pop_valid);
    mq.delete();
    mstall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stall counter saturation
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one(32'h6000_0000 + 32'(i), 32'(i * 4));
    push_valid = 1'b1;
    push_instr = 32'h6000_00FF;
    for (int i = 0; i < 20; i++) step();
    #1;
    chk("sat_stall", 64'(stall_cnt), 64'hF);
    step();
    step();
    #1;
    chk("sat_hold", 64'(stall_cnt), 64'hF);
    $display("stall saturation: stall_cnt=%0h", stall_cnt);
    push_valid = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      push_instr = $urandom;
      push_npc   = $urandom;
      pop_ready  = 1'($urandom_range(0, 2) != 0);
      flush      = 1'($urandom_range(0, 15) == 0);
      if (i % 50 == 0)
        $display("random %0d: count=%0d stall=%0d", i, count, stall_cnt);
      step();
    end
    push_valid = 1'b0;
    flush      = 1'b0;
    pop_ready  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised instruction queue decoupling the fetch stage from the decode stage, replacing the fixed single-entry IF/ID latch. Holds up to DEPTH {instruction, next-PC} pairs with a valid/ready handshake on both sides. Adds a synchronous flush for taken branches and a saturating stall counter. Sits between the fetch and decode stages inside the pipeline top.

Parameters:
INSTR_W, 32, instruction width in bits
NPC_W, 32, next-PC width in bits
DEPTH, 4, number of entries; power of two, minimum 2
NOP_INSTR, 32'h0000_0000, value driven on pop_instr when no valid entry is presented (MIPS sll $0,$0,0)
STALL_W, 16, width of the stall statistics counter

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; asynchronous, active-high
push_valid  input  1  fetch presents an entry
push_ready  output  1  queue can accept an entry
push_instr  input  INSTR_W  fetched instruction
push_npc  input  NPC_W  PC+4 of fetched instruction
pop_valid  output  1  head entry valid for decode
pop_ready  input  1  decode consumes head
pop_instr  output  INSTR_W  head instruction, or NOP_INSTR when pop_valid=0
pop_npc  output  NPC_W  head next-PC, or 0 when pop_valid=0
flush  input  1  discard all contents (EX/MEM branch taken)
count  output  log2(DEPTH)+1  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
stall_cnt  output  STALL_W  cycles with push_valid=1 and push_ready=0

Behaviour:
- Reset (async, while rst=1): wr_ptr=0, rd_ptr=0, count=0, stall_cnt=0; consequently push_ready=1, pop_valid=0, pop_instr=NOP_INSTR, pop_npc=0, full=0, empty=1. Storage array is not reset. Reset mid-operation discards all entries immediately.
- push fire = push_valid & push_ready & ~flush; pop fire = pop_valid & pop_ready.
- push_ready = ~full. No combinational path from pop_ready to push_ready, so a full queue refuses a push even when a pop fires in the same cycle.
- pop_valid = ~empty & ~flush. Head outputs come from the storage addressed by rd_ptr (combinational read). pop_instr/pop_npc are forced to NOP_INSTR/0 whenever pop_valid=0.
- Latency: an entry pushed in cycle N is visible on pop_valid/pop_instr in cycle N+1. There is no same-cycle bypass.
- Push fire: write mem[wr_ptr] and increment wr_ptr modulo DEPTH (natural wrap of the log2(DEPTH)-bit pointer).
- Pop fire: increment rd_ptr modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop (only possible when not full and not empty).
- Flush (synchronous, highest priority):
  - Next edge sets wr_ptr=0, rd_ptr=0, count=0.
  - A push in the flush cycle is dropped, and no pop fires (pop_valid=0).
  - In the cycle after flush, empty=1 and push_ready=1.
  - Back-to-back flush cycles keep the queue empty.
- stall_cnt increments by 1 each cycle with push_valid=1 and push_ready=0, and saturates at all-ones. Flush does not clear it; only rst does.
- Invariants:
  - count never exceeds DEPTH and never goes negative.
  - Pop attempts while empty and push attempts while full change no state other than stall_cnt.

Decomposition:
- Shared include file src/pipeline_defs.vh holds:
  - the NOP encoding constant;
  - default instruction/NPC widths;
  - the log2 helper macro for pointer and count widths.
  The pipeline top and the fetch/decode stages use the same file.
- One sub-module: fetch_decode_queue_mem.
  - DEPTH x (INSTR_W+NPC_W) register array.
  - One synchronous write port and one asynchronous read port.
  - No reset.
- Pointer, count, flush and stall logic stay in fetch_decode_queue.

Test Plan:
- Reset check: hold rst=1 for 3 cycles, then release. Required: count=0, empty=1, full=0, push_ready=1, pop_valid=0, pop_instr=32'h0, stall_cnt=0.
- Fill and drain (DEPTH=4): push 32'h2001_0001..32'h2001_0004 with npc 4,8,12,16 while pop_ready=0. Required: full=1 after the 4th edge. A 5th push is refused and stall_cnt=1. With pop_ready=1, the entries come out in order over 4 cycles, then empty=1.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, output order is preserved, and pointers wrap past 3 to 0 without corruption.
- Flush with count=3 while push_valid=1 (32'hDEAD_BEEF): next cycle count=0, pop_valid=0, pop_instr=NOP. The 32'hDEAD_BEEF entry never appears.
- Async reset mid-stream: assert rst between clock edges with count=2. Required: outputs go to reset values immediately, without waiting for a clock edge.
- Stall saturation with STALL_W=4: keep the queue full with push_valid=1 for 20 cycles. Required: stall_cnt reaches 4'hF and holds.
